// File: rtl/fifo_stream_reader.sv
// Pulls words out of a synchronous FIFO and presents them as a valid/ready stream.
// A 2-entry skid buffer absorbs the FIFO's one-cycle read latency, so the stream can move one word per cycle.
module fifo_stream_reader #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             empty,
  input  logic [WIDTH-1:0] rd_data,
  input  logic             rd_error,
  output logic             rd_en,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             busy,
  output logic             err_flag,
  output logic [15:0]      word_count
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACTIVE   = 2'd1,
    STOPPING = 2'd2
  } state_t;

  state_t                      state, state_nxt;
  logic [1:0]                  count;
  logic                        pend;
  logic [1:0][WIDTH-1:0]       slots;
  logic                        pop;
  logic                        append;
  logic                        drop;
  logic [2:0]                  occ_nxt;

  assign pop     = out_valid && out_ready;
  assign append  = pend && !rd_error;
  assign drop    = pend && rd_error;

  // Occupancy after this edge if nothing new is read; a read is only issued when a slot is guaranteed.
  assign occ_nxt = {1'b0, count} + {2'b00, pend} - {2'b00, pop};

  // Reads are gated by enable alone, not by state: the edge leaving IDLE already samples rd_en,
  // which gives the two-edge enable-to-data latency. STOPPING only exists with enable low.
  assign rd_en     = !rst && enable && !empty && (occ_nxt < 3'd2);
  assign out_valid = (count != 2'd0);
  assign out_data  = out_valid ? slots[0] : '0;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count      <= 2'd0;
      pend       <= 1'b0;
      slots      <= '0;
      err_flag   <= 1'b0;
      word_count <= 16'd0;
    end else begin
      pend <= rd_en;
      if (drop) err_flag <= 1'b1;
      if (pop)  word_count <= word_count + 16'd1;
      case ({pop, append})
        2'b10: begin
          slots[0] <= slots[1];
          count    <= count - 2'd1;
        end
        2'b01: begin
          if (count == 2'd0) slots[0] <= rd_data;
          else               slots[1] <= rd_data;
          count <= count + 2'd1;
        end
        2'b11: begin
          // head leaves, new word lands behind whatever remains
          if (count == 2'd1) begin
            slots[0] <= rd_data;
          end else begin
            slots[0] <= slots[1];
            slots[1] <= rd_data;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (enable) state_nxt = ACTIVE;
      end
      ACTIVE: begin
        if (!enable) state_nxt = ((count != 2'd0) || pend) ? STOPPING : IDLE;
      end
      STOPPING: begin
        if (enable)                          state_nxt = ACTIVE;
        else if ((count == 2'd0) && !pend)   state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  a_occ_bound: assert property (@(posedge clk) disable iff (rst) ({1'b0, count} + {2'b00, pend}) <= 3'd2);
  a_no_rd_empty: assert property (@(posedge clk) disable iff (rst) !(rd_en && empty));

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: behavioural sync FIFO in front, stream scoreboard behind.
module tb_fifo_stream_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        empty = 1'b1;
  logic [7:0]  rd_data = 8'h00;
  logic        rd_error = 1'b0;
  logic        rd_en;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready = 1'b0;
  logic        busy;
  logic        err_flag;
  logic [15:0] word_count;

  fifo_stream_reader #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .enable(enable), .empty(empty), .rd_data(rd_data),
    .rd_error(rd_error), .rd_en(rd_en), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .busy(busy), .err_flag(err_flag), .word_count(word_count)
  );

  always #5 clk = ~clk;

  logic [7:0] q[$];
  logic [7:0] exp_q[$];
  logic [7:0] got[$];
  int n_issued = 0, n_errd = 0, pops_done = 0, err_req = 0, err_done = 0;
  int checks = 0, errors = 0;

  // Sync FIFO model: data/error appear the cycle after rd_en is sampled; a read marked
  // for error injection never joins the expected stream.
  always @(posedge clk) begin
    if (out_valid && out_ready && !rst) pops_done <= pops_done + 1;
    if (rd_error) n_errd <= n_errd + 1;
    if (rd_en && q.size() > 0) begin
      n_issued <= n_issued + 1;
      rd_data  <= q[0];
      if (err_req != err_done) begin
        rd_error <= 1'b1;
        err_done <= err_done + 1;
      end else begin
        rd_error <= 1'b0;
        exp_q.push_back(q[0]);
      end
      void'(q.pop_front());
    end else begin
      rd_error <= 1'b0;
    end
    empty <= (q.size() == 0);
  end

  always @(negedge clk)
    if (out_valid && out_ready) got.push_back(out_data);

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; enable = 1'b0; out_ready = 1'b0;
    q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    err_req = err_done;
    got.delete(); exp_q.delete();
  endtask

  task automatic test_reset;
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", out_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (word_count !== 16'd0) begin errors++; $display("FAIL reset_wc got %0d exp 0", word_count); end
    checks++; if (err_flag !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err_flag); end
    q.push_back(8'h55); enable = 1'b1;
    repeat (2) @(posedge clk); #1;
    checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL reset_rden got %b exp 0 (empty=%b)", rd_en, empty); end
    do_reset();
  endtask

  task automatic test_streaming;
    do_reset();
    for (int i = 0; i < 4; i++) q.push_back(8'h11 + 8'(i));
    tick();
    enable = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== (i >= 2)) begin errors++; $display("FAIL stream_valid cyc %0d got %b exp %b", i, out_valid, (i >= 2)); end
      if (i >= 2) begin
        checks++;
        if (out_data !== 8'h11 + 8'(i - 2)) begin errors++; $display("FAIL stream_data cyc %0d got %h exp %h", i, out_data, 8'h11 + 8'(i - 2)); end
      end
    end
    @(negedge clk);
    checks++; if (word_count !== 16'd4) begin errors++; $display("FAIL stream_wc got %0d exp 4", word_count); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stream_busy got %b exp 1", busy); end
    @(posedge clk); #1 enable = 1'b0;
    tick(); tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stream_idle got busy=%b exp 0", busy); end
  endtask

  task automatic test_backpressure;
    int base;
    do_reset();
    for (int i = 0; i < 3; i++) q.push_back(8'hA0 + 8'(i));
    tick();
    base = n_issued;
    enable = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) begin
        checks++;
        if (out_data !== 8'hA0) begin errors++; $display("FAIL bp_hold cyc %0d got %h exp a0", i, out_data); end
      end
    end
    checks++; if (n_issued - base !== 2) begin errors++; $display("FAIL bp_reads got %0d exp 2", n_issued - base); end
    checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL bp_rden got %b exp 0", rd_en); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got %b exp 1", out_valid); end
    @(posedge clk); #1 out_ready = 1'b1;
    repeat (6) tick();
    checks++; if (n_issued - base !== 3) begin errors++; $display("FAIL bp_reads_after got %0d exp 3", n_issued - base); end
    checks++;
    if (got.size() != 3) begin errors++; $display("FAIL bp_count got %0d exp 3", got.size()); end
    else if (got[0] !== 8'hA0 || got[1] !== 8'hA1 || got[2] !== 8'hA2) begin
      errors++; $display("FAIL bp_order got %h %h %h exp a0 a1 a2", got[0], got[1], got[2]);
    end
  endtask

  task automatic test_empty;
    int base, ebase;
    do_reset();
    q.push_back(8'hE7);
    tick();
    base = n_issued; ebase = n_errd;
    enable = 1'b1; out_ready = 1'b1;
    repeat (8) tick();
    checks++; if (n_issued - base !== 1) begin errors++; $display("FAIL empty_reads got %0d exp 1", n_issued - base); end
    checks++; if (n_errd - ebase !== 0) begin errors++; $display("FAIL empty_rderr got %0d exp 0", n_errd - ebase); end
    checks++; if (err_flag !== 1'b0) begin errors++; $display("FAIL empty_errflag got %b exp 0", err_flag); end
    checks++;
    if (got.size() != 1) begin errors++; $display("FAIL empty_count got %0d exp 1", got.size()); end
    else if (got[0] !== 8'hE7) begin errors++; $display("FAIL empty_data got %h exp e7", got[0]); end
  endtask

  task automatic test_underflow;
    do_reset();
    for (int i = 0; i < 3; i++) q.push_back(8'hB0 + 8'(i));
    err_req++;
    tick();
    enable = 1'b1; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL uf_count got valid=%b exp 0", out_valid); end
    checks++; if (err_flag !== 1'b1) begin errors++; $display("FAIL uf_flag got %b exp 1", err_flag); end
    repeat (8) tick();
    checks++;
    if (got.size() != 2) begin errors++; $display("FAIL uf_words got %0d exp 2", got.size()); end
    else if (got[0] !== 8'hB1 || got[1] !== 8'hB2) begin errors++; $display("FAIL uf_order got %h %h exp b1 b2", got[0], got[1]); end
    checks++; if (word_count !== 16'd2) begin errors++; $display("FAIL uf_wc got %0d exp 2", word_count); end
    enable = 1'b0;
    repeat (20) tick();
    checks++; if (err_flag !== 1'b1) begin errors++; $display("FAIL uf_sticky got %b exp 1", err_flag); end
    do_reset();
    checks++; if (err_flag !== 1'b0) begin errors++; $display("FAIL uf_clear got %b exp 0", err_flag); end
  endtask

  task automatic test_stop;
    int base;
    do_reset();
    for (int i = 0; i < 3; i++) q.push_back(8'hC0 + 8'(i));
    tick();
    base = n_issued;
    out_ready = 1'b0; enable = 1'b1;
    tick(); tick();
    enable = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stop_pre_valid got %b exp 1", out_valid); end
    tick();
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stop_busy got %b exp 1", busy); end
    checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL stop_rden got %b exp 0 (empty=%b)", rd_en, empty); end
    @(posedge clk); #1 out_ready = 1'b1;
    repeat (6) tick();
    checks++;
    if (got.size() != 2) begin errors++; $display("FAIL stop_words got %0d exp 2", got.size()); end
    else if (got[0] !== 8'hC0 || got[1] !== 8'hC1) begin errors++; $display("FAIL stop_order got %h %h exp c0 c1", got[0], got[1]); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_idle got busy=%b exp 0", busy); end
    checks++; if (n_issued - base !== 2) begin errors++; $display("FAIL stop_reads got %0d exp 2", n_issued - base); end
    q.delete();
  endtask

  task automatic test_reset_mid;
    do_reset();
    q.push_back(8'hD0);
    tick();
    enable = 1'b1; out_ready = 1'b1;
    repeat (5) tick();
    out_ready = 1'b0;
    for (int i = 1; i < 4; i++) q.push_back(8'hD0 + 8'(i));
    repeat (6) tick();
    checks++; if (word_count !== 16'd1) begin errors++; $display("FAIL mid_pre_wc got %0d exp 1", word_count); end
    checks++; if (out_valid !== 1'b1 || out_data !== 8'hD1) begin errors++; $display("FAIL mid_pre got valid=%b data=%h exp 1 d1", out_valid, out_data); end
    #1 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b exp 0", out_valid); end
    checks++; if (word_count !== 16'd0) begin errors++; $display("FAIL mid_wc got %0d exp 0", word_count); end
    checks++; if (out_data !== 8'h00 || busy !== 1'b0 || rd_en !== 1'b0) begin errors++; $display("FAIL mid_outs got data=%h busy=%b rd_en=%b exp 00 0 0", out_data, busy, rd_en); end
    q.delete();
    @(posedge clk); #1 rst = 1'b0;
    got.delete(); exp_q.delete();
    out_ready = 1'b1; enable = 1'b1;
    repeat (8) tick();
    checks++; if (got.size() != 0) begin errors++; $display("FAIL mid_stale got %0d words exp 0", got.size()); end
    checks++; if (word_count !== 16'd0) begin errors++; $display("FAIL mid_wc_after got %0d exp 0", word_count); end
  endtask

  task automatic test_random;
    int b_iss, b_err, b_pop, occ, bad;
    logic prev_hold;
    logic [7:0] prev_data;
    do_reset();
    b_iss = n_issued; b_err = n_errd; b_pop = pops_done;
    prev_hold = 1'b0; prev_data = 8'h00;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if ($urandom_range(1) == 0) q.push_back(8'($urandom));
      out_ready = ($urandom_range(3) != 0);
      if ($urandom_range(15) == 0) enable = ~enable;
      if ($urandom_range(63) == 0 && err_req == err_done) err_req++;
      @(negedge clk);
      checks++; if (rd_en && empty) begin errors++; $display("FAIL rnd_rd_empty cyc %0d got rd_en=1 exp 0", c); end
      occ = (n_issued - b_iss) - (n_errd - b_err) - (pops_done - b_pop);
      checks++; if (occ > 2) begin errors++; $display("FAIL rnd_occ cyc %0d got %0d exp <=2", c, occ); end
      if (prev_hold) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== prev_data) begin errors++; $display("FAIL rnd_stable cyc %0d got %b/%h exp 1/%h", c, out_valid, out_data, prev_data); end
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
    end
    @(posedge clk); #1 enable = 1'b1; out_ready = 1'b1;
    while (q.size() > 0 || exp_q.size() != got.size()) begin
      if (pops_done - b_pop > 4000) break;
      tick();
      if (q.size() == 0) begin repeat (6) tick(); break; end
    end
    checks++; if (got.size() != exp_q.size()) begin errors++; $display("FAIL rnd_count got %0d exp %0d", got.size(), exp_q.size()); end
    bad = 0;
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) if (got[i] !== exp_q[i]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL rnd_order got %0d mismatching words exp 0", bad); end
    checks++; if (word_count !== 16'(got.size())) begin errors++; $display("FAIL rnd_wc got %0d exp %0d", word_count, got.size()); end
    checks++; if (err_flag !== (n_errd - b_err > 0)) begin errors++; $display("FAIL rnd_errflag got %b exp %b", err_flag, (n_errd - b_err > 0)); end
  endtask

  task automatic test_wrap;
    int bad;
    do_reset();
    for (int i = 0; i < 65537; i++) q.push_back(i[7:0]);
    tick();
    enable = 1'b1; out_ready = 1'b1;
    repeat (65545) tick();
    checks++; if (got.size() != 65537) begin errors++; $display("FAIL wrap_count got %0d exp 65537", got.size()); end
    checks++; if (word_count !== 16'd1) begin errors++; $display("FAIL wrap_wc got %0d exp 1", word_count); end
    bad = 0;
    for (int i = 0; i < got.size(); i++) if (got[i] !== i[7:0]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL wrap_order got %0d mismatching words exp 0", bad); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_empty();
    test_underflow();
    test_stop();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
